// File: rtl/bcd_scan_display.sv
// Three-digit multiplexed seven-segment driver for a packed BCD result.
// A load strobe fills a pending buffer that is copied to the display only at frame boundaries.
module bcd_scan_display #(
  parameter int DIV   = 27000,
  parameter int BLANK = 16,
  parameter bit LZB   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd,
  input  logic        neg,
  input  logic        ovf,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  dig,
  output logic        upd
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {S_ONES, S_TENS, S_HUND} state_t;

  // Word layout in pending/display registers: {ovf, neg, bcd[11:0]}
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [13:0]   pend_q, pend_d;
  logic          pend_flag_q, pend_flag_d;
  logic [13:0]   disp_q, disp_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [2:0]    dig_q, dig_d;
  logic          upd_q, upd_d;

  logic          tick;
  logic          boundary;
  logic [3:0]    nib;
  logic [3:0]    hund;
  logic [3:0]    tens;
  logic          blank_digit;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0000110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      state_q     <= S_ONES;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      disp_q      <= '0;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      dig_q       <= 3'b111;
      upd_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      disp_q      <= disp_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      dig_q       <= dig_d;
      upd_q       <= upd_d;
    end
  end

  always_comb begin
    tick        = (cnt_q == CNT_LAST);
    cnt_d       = tick ? '0 : cnt_q + CW'(1);
    state_d     = state_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    disp_d      = disp_q;
    upd_d       = 1'b0;
    seg_d       = SEG_OFF;
    dp_d        = 1'b1;
    dig_d       = 3'b111;
    nib         = 4'h0;
    hund        = disp_q[11:8];
    tens        = disp_q[7:4];
    blank_digit = 1'b0;
    boundary    = tick && (state_q == S_HUND);

    if (tick) begin
      case (state_q)
        S_ONES:  state_d = S_TENS;
        S_TENS:  state_d = S_HUND;
        default: state_d = S_ONES;
      endcase
    end

    // A load on the boundary edge lands in pending after the old value moves out
    if (boundary && pend_flag_q) begin
      disp_d      = pend_q;
      pend_flag_d = 1'b0;
      upd_d       = 1'b1;
    end
    if (load) begin
      pend_d      = {ovf, neg, bcd};
      pend_flag_d = 1'b1;
    end

    case (state_q)
      S_ONES: begin
        nib   = disp_q[3:0];
        dig_d = 3'b110;
      end
      S_TENS: begin
        nib         = tens;
        dig_d       = 3'b101;
        blank_digit = LZB && (hund == 4'h0) && (tens == 4'h0);
      end
      S_HUND: begin
        nib         = hund;
        dig_d       = 3'b011;
        blank_digit = LZB && (hund == 4'h0);
      end
      default: begin
        nib   = 4'h0;
        dig_d = 3'b111;
      end
    endcase

    if (disp_q[13])
      seg_d = SEG_DASH;
    else if (blank_digit)
      seg_d = SEG_OFF;
    else
      seg_d = seg7(nib);

    // Sign shows on the hundreds point even when that digit itself is blanked
    dp_d = !((state_q == S_HUND) && disp_q[12] && !disp_q[13]);

    if (cnt_q < CNT_BLANK) begin
      dig_d = 3'b111;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign dig = dig_q;
  assign upd = upd_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: a cycle-count based model checks every cycle,
// directed loads pin the glyphs, blanking, overflow and frame-boundary behaviour.
module tb_bcd_scan_display;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 3 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] bcd = '0;
  logic        neg = 1'b0;
  logic        ovf = 1'b0;
  logic        load = 1'b0;

  logic [6:0]  seg1, seg0;
  logic        dp1, dp0;
  logic [2:0]  dig1, dig0;
  logic        upd1, upd0;

  int n_chk  = 0;
  int n_fail = 0;

  bcd_scan_display #(.DIV(DIV), .BLANK(BLANK), .LZB(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bcd(bcd), .neg(neg), .ovf(ovf), .load(load),
    .seg(seg1), .dp(dp1), .dig(dig1), .upd(upd1)
  );

  bcd_scan_display #(.DIV(DIV), .BLANK(BLANK), .LZB(1'b0)) u_dut_nolzb (
    .clk(clk), .rst(rst), .bcd(bcd), .neg(neg), .ovf(ovf), .load(load),
    .seg(seg0), .dp(dp0), .dig(dig0), .upd(upd0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycle index since reset decides slot and phase; words flow through a pending buffer
  int          m_c = 0;
  logic [13:0] m_pend = '0;
  bit          m_flag = 1'b0;
  logic [13:0] m_disp = '0;
  logic [2:0]  e_dig = 3'b111;
  logic [6:0]  e_seg1 = 7'h7F;
  logic [6:0]  e_seg0 = 7'h7F;
  logic        e_dp = 1'b1;
  logic        e_upd = 1'b0;
  bit          e_active = 1'b0;
  int          m_d, m_p;

  function automatic logic [6:0] glyph(input logic [13:0] w, input int d, input bit lzb);
    logic [3:0] h, t, n;
    h = w[11:8];
    t = w[7:4];
    n = w[d*4 +: 4];
    if (w[13]) return 7'b0111111;
    if (lzb && ((d == 2 && h == 0) || (d == 1 && h == 0 && t == 0))) return 7'h7F;
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0000110;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_c = 0; m_pend = '0; m_flag = 1'b0; m_disp = '0;
      e_dig = 3'b111; e_upd = 1'b0; e_active = 1'b0;
      e_seg1 = 7'h7F; e_seg0 = 7'h7F; e_dp = 1'b1;
    end else begin
      m_p = m_c % DIV;
      m_d = (m_c / DIV) % 3;
      e_active = (m_p >= BLANK);
      e_dig = e_active ? ~(3'b001 << m_d) : 3'b111;
      e_seg1 = glyph(m_disp, m_d, 1'b1);
      e_seg0 = glyph(m_disp, m_d, 1'b0);
      e_dp = !(m_d == 2 && m_disp[12] && !m_disp[13]);
      e_upd = ((m_c % FRAME) == FRAME - 1) && m_flag;
      if (e_upd) begin
        m_disp = m_pend;
        m_flag = 1'b0;
      end
      if (load) begin
        m_pend = {ovf, neg, bcd};
        m_flag = 1'b1;
      end
      m_c++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("dig", dig1, e_dig);
      chk("dig_nolzb", dig0, e_dig);
      chk("upd", upd1, e_upd);
      chk("upd_nolzb", upd0, e_upd);
      if (e_active) begin
        chk("seg", seg1, e_seg1);
        chk("seg_nolzb", seg0, e_seg0);
        chk("dp", dp1, e_dp);
        chk("dp_nolzb", dp0, e_dp);
      end
    end
  end

  task automatic do_load(input logic [11:0] b, input logic n, input logic o);
    @(negedge clk);
    bcd = b; neg = n; ovf = o; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_upd(input string name);
    bit found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (upd1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_upd_seen"}, found, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_phase(input int r);
    for (int k = 0; k < 100; k++) begin
      if ((m_c % FRAME) == r) break;
      @(negedge clk);
    end
  endtask

  task automatic check_digit(input bit lzb, input int d, input logic [6:0] es,
                             input logic edp, input string name);
    logic [2:0] want;
    bit found = 1'b0;
    want = ~(3'b001 << d);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((lzb ? dig1 : dig0) == want) begin
        found = 1'b1;
        break;
      end
    end
    chk({name, "_slot_seen"}, found, 1'b1);
    chk({name, "_seg"}, lzb ? seg1 : seg0, es);
    chk({name, "_dp"}, lzb ? dp1 : dp0, edp);
  endtask

  initial begin
    bit seen;
    #1 rst = 1'b1;
    #1;
    chk("rst_seg", seg1, 7'h7F);
    chk("rst_dp", dp1, 1'b1);
    chk("rst_dig", dig1, 3'b111);
    chk("rst_upd", upd1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    do_load(12'h123, 1'b0, 1'b0);
    wait_upd("w123");
    check_digit(1'b1, 0, 7'b0110000, 1'b1, "d123_ones");
    check_digit(1'b1, 1, 7'b0100100, 1'b1, "d123_tens");
    check_digit(1'b1, 2, 7'b1111001, 1'b1, "d123_hund");

    do_load(12'h007, 1'b0, 1'b0);
    wait_upd("w007");
    check_digit(1'b1, 2, 7'h7F, 1'b1, "d007_hund");
    check_digit(1'b1, 0, 7'b1111000, 1'b1, "d007_ones");
    check_digit(1'b1, 1, 7'h7F, 1'b1, "d007_tens");

    do_load(12'h000, 1'b0, 1'b0);
    wait_upd("w000");
    check_digit(1'b0, 0, 7'b1000000, 1'b1, "d000_ones_nolzb");
    check_digit(1'b0, 1, 7'b1000000, 1'b1, "d000_tens_nolzb");
    check_digit(1'b0, 2, 7'b1000000, 1'b1, "d000_hund_nolzb");

    do_load(12'h0A5, 1'b0, 1'b0);
    wait_upd("w0a5");
    check_digit(1'b1, 0, 7'b0010010, 1'b1, "d0a5_ones");
    check_digit(1'b1, 1, 7'b0000110, 1'b1, "d0a5_tens");
    check_digit(1'b1, 2, 7'h7F, 1'b1, "d0a5_hund");

    do_load(12'h456, 1'b0, 1'b1);
    wait_upd("wovf");
    check_digit(1'b1, 0, 7'b0111111, 1'b1, "ovf_ones");
    check_digit(1'b1, 1, 7'b0111111, 1'b1, "ovf_tens");
    check_digit(1'b1, 2, 7'b0111111, 1'b1, "ovf_hund");

    do_load(12'h009, 1'b1, 1'b0);
    wait_upd("wneg");
    check_digit(1'b1, 0, 7'b0010000, 1'b1, "neg_ones");
    check_digit(1'b1, 2, 7'h7F, 1'b0, "neg_hund");

    // Two back-to-back loads well away from the boundary
    wait_phase(2);
    bcd = 12'h111; neg = 1'b0; ovf = 1'b0; load = 1'b1;
    @(negedge clk);
    bcd = 12'h222;
    @(negedge clk);
    load = 1'b0;
    wait_upd("w222");
    check_digit(1'b1, 2, 7'b0100100, 1'b1, "d222_hund");
    check_digit(1'b1, 0, 7'b0100100, 1'b1, "d222_ones");

    // 333 pending, then 444 arrives on the boundary edge itself
    wait_phase(1);
    bcd = 12'h333; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_phase(FRAME - 1);
    bcd = 12'h444; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_upd("w333");
    check_digit(1'b1, 2, 7'b0110000, 1'b1, "d333_hund");
    wait_upd("w444");
    check_digit(1'b1, 2, 7'b0011001, 1'b1, "d444_hund");

    // Asynchronous reset in the middle of the tens slot
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dig1 == 3'b101) begin
        seen = 1'b1;
        break;
      end
    end
    chk("tens_before_rst", seen, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_seg", seg1, 7'h7F);
    chk("arst_dp", dp1, 1'b1);
    chk("arst_dig", dig1, 3'b111);
    chk("arst_upd", upd1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dig1 != 3'b111) begin
        seen = 1'b1;
        break;
      end
    end
    chk("post_rst_active", seen, 1'b1);
    chk("post_rst_first_slot", dig1, 3'b110);
    chk("post_rst_ones_seg", seg1, 7'b1000000);
    check_digit(1'b1, 2, 7'h7F, 1'b1, "post_rst_hund");

    repeat (2 * FRAME) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Sequential back end for the ALU's 3-digit BCD result. Accepts a 12-bit packed BCD word plus status flags through a load strobe.
- Buffers each word tear-free and time-multiplexes it onto a 3-digit common-anode seven-segment display.
- Features: refresh prescaler, digit-scan FSM, anti-ghost blanking, leading-zero suppression, invalid-digit and overflow indication.
- Sits between the ALU/selector output and the board display pins.

Parameters:
- DIV, 27000, clk cycles per digit slot (27 MHz clock gives a 1 kHz slot rate); legal range 4..2^20.
- BLANK, 16, cycles at the start of each slot with all anodes off; must be < DIV.
- LZB, 1, 1 enables leading-zero blanking; 0 shows all digits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- bcd  in  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] ones
- neg  in  1  result negative; lights the decimal point of the hundreds digit
- ovf  in  1  overflow; overrides digits with dashes
- load  in  1  capture strobe, sampled every clk edge
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- dig  out  3  anodes, active-low: [0] ones, [1] tens, [2] hundreds
- upd  out  1  one-cycle pulse when a new word reaches the display register

Behaviour:
- Interface: one clock. Reset is asynchronous and active-high. Clock and reset ports are named clk and rst.
- Reset values (asynchronous): prescaler 0, slot counter 0, FSM in S_ONES, pending register 0, pending flag 0, display register 0, seg=7'h7F, dp=1, dig=3'b111, upd=0. Reset asserted mid-frame aborts the scan immediately; the first slot after release is S_ONES.
- Capture:
  - load=1 at an edge writes {ovf,neg,bcd} into the pending register and sets the pending flag.
  - Back-to-back loads overwrite; the last one wins.
  - Bits are not checked at capture.
- Prescaler: counts 0..DIV-1 and wraps to 0. tick=1 when count==DIV-1. The slot counter resets to 0 on tick.
- FSM: S_ONES -> S_TENS -> S_HUND -> S_ONES, advancing only on tick.
- Frame boundary is tick while in S_HUND:
  - If the pending flag is set, the display register takes the pending register, the flag clears, and upd=1 for exactly that cycle.
  - If load coincides with the boundary, the display takes the old pending value. The new value enters pending and the flag stays set, so it displays one frame later.
- Anti-ghost: while slot counter < BLANK, dig=3'b111. Otherwise exactly one dig bit is 0, for the current state.
- Digit decode: 0-9 use standard glyphs. Nibble >9 shows 'E' (segments a,d,e,f,g on).
- Leading-zero blanking (LZB=1):
  - Hundreds is blank when it is 0.
  - Tens is blank when hundreds and tens are both 0.
  - Ones is never blank.
  - A blank digit has seg=7'h7F.
  - An invalid hundreds digit (>9) is not blanked.
- Overflow: ovf=1 in the display register forces every digit to '-' (only g on). Blanking is ignored and dp is off.
- dp=0 only in S_HUND with display neg=1 and ovf=0. This holds even when hundreds is blanked.
- seg, dp and dig are registered and lag the FSM state by one clk. seg/dp are valid whenever the matching dig bit is low.
- upd and the display register are never asserted or updated outside a frame boundary.

Test Plan:
- DIV=4, BLANK=1: reset, then load bcd=12'h123 -> upd pulses once at the first S_HUND tick. The next frame shows ones seg=7'b0110000 ('3'), tens '2' (7'b0100100), hundreds '1' (7'b1111001). Each digit is low for 3 of every 4 cycles with dig=111 on the first.
- LZB=1, load bcd=12'h007 -> hundreds and tens slots have seg=7'h7F, ones shows '7'. With LZB=0, the 12'h000 pattern shows "0" in all three slots.
- load bcd=12'h0A5 -> tens shows 'E' (7'b0000110). Hundreds is blank, ones shows '5'.
- load ovf=1, bcd=12'h456 -> all slots show 7'b0111111 with dp=1. Then load neg=1, ovf=0, bcd=12'h009 -> hundreds slot has seg=7'h7F and dp=0.
- Load 12'h111 then 12'h222 on consecutive cycles mid-frame -> only 222 is displayed, with a single upd. Load coinciding with the boundary tick -> displayed one frame later.
- Assert rst mid-S_TENS -> outputs go to their reset values asynchronously before the next edge. After release the scan restarts at S_ONES with the display register at 0.
